// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
package div_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a requester and the sequential divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);

    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );

endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dmag,
    output logic [N-1:0] rem_next_c,
    output logic         qbit_c
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // The kept remainder is always below dmag <= 2^(N-1), so N bits hold it.
    always_comb begin
        shifted    = {rem_in, bit_in};
        diff       = shifted - {1'b0, dmag};
        qbit_c     = (shifted >= {1'b0, dmag});
        rem_next_c = N'(qbit_c ? diff : shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: 2N restoring steps on magnitudes, then a sign fix.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  DVD_MIN  = W'(1) << (W - 1);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   work;
    logic [N-1:0]   prem;
    logic [N-1:0]   dmag;
    logic           neg_q;
    logic           neg_r;
    logic           dbz_flag;
    logic           ovf_flag;

    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   quotient_r;
    logic [N-1:0]   remainder_r;
    logic           dbz_r;
    logic           ovf_r;

    logic [N-1:0]   rem_next_c;
    logic           qbit_c;
    logic [W-1:0]   dvd_mag_c;
    logic [N-1:0]   dvs_mag_c;

    // Unsigned magnitudes: the most negative operands map to exact powers of two.
    always_comb begin
        dvd_mag_c = bus.dividend[W-1] ? (W'(0) - bus.dividend) : bus.dividend;
        dvs_mag_c = bus.divisor[N-1]  ? (N'(0) - bus.divisor)  : bus.divisor;
    end

    div_step #(.N(N)) u_step (
        .rem_in     (prem),
        .bit_in     (work[W-1]),
        .dmag       (dmag),
        .rem_next_c (rem_next_c),
        .qbit_c     (qbit_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration, sign fix and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            work        <= '0;
            prem        <= '0;
            dmag        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_flag    <= 1'b0;
            ovf_flag    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            busy_r <= (state_next == CALC) || (state_next == FIX);
            done_r <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work     <= dvd_mag_c;
                        dmag     <= dvs_mag_c;
                        prem     <= '0;
                        cnt      <= '0;
                        neg_q    <= bus.dividend[W-1] ^ bus.divisor[N-1];
                        neg_r    <= bus.dividend[W-1];
                        dbz_flag <= (bus.divisor == '0);
                        ovf_flag <= (bus.dividend == DVD_MIN) && (bus.divisor == '1);
                    end
                end
                CALC: begin
                    work <= {work[W-2:0], qbit_c};
                    prem <= rem_next_c;
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    dbz_r <= dbz_flag;
                    ovf_r <= ovf_flag;
                    if (dbz_flag) begin
                        quotient_r  <= '1;
                        remainder_r <= '0;
                    end else if (ovf_flag) begin
                        quotient_r  <= DVD_MIN;
                        remainder_r <= '0;
                    end else begin
                        quotient_r  <= neg_q ? (W'(0) - work) : work;
                        remainder_r <= neg_r ? (N'(0) - prem) : prem;
                    end
                end
                default: ;
            endcase
        end
    end

    // Drive the result side of the bundle.
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N = 4).
module tb_seq_divider;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_divider_if #(.N(4)) bus ();

    seq_divider #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One operation from a start pulse; optionally re-pulse start mid-CALC.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic ez, input logic eo, input bit noise);
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'hA5;
        bus.divisor  = 4'h6;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (noise && n == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'h5A;
                bus.divisor  = 4'h3;
            end
            if (noise && n == 6) bus.start = 1'b0;
        end
        chk({tag, ".lat"}, 32'(n), 32'd10);
        chk({tag, ".q"},   32'(bus.quotient),  32'(eq));
        chk({tag, ".r"},   32'(bus.remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(bus.dbz), 32'(ez));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'({bus.done, bus.busy}), 32'd0);
    endtask

    initial begin
        int n;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", 32'({bus.busy, bus.done, bus.dbz, bus.ovf, bus.quotient, bus.remainder}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived results.
        run_op("7/2",     8'd7,   4'd2,  8'h03, 4'h1, 1'b0, 1'b0, 1'b0);
        run_op("-7/2",    8'hF9,  4'd2,  8'hFD, 4'hF, 1'b0, 1'b0, 1'b0);
        run_op("100/-7",  8'd100, 4'h9,  8'hF2, 4'h2, 1'b0, 1'b0, 1'b0);
        run_op("min/-1",  8'h80,  4'hF,  8'h80, 4'h0, 1'b0, 1'b1, 1'b0);
        run_op("min/-8",  8'h80,  4'h8,  8'h10, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("55/0",    8'd55,  4'h0,  8'hFF, 4'h0, 1'b1, 1'b0, 1'b0);
        run_op("127/7",   8'h7F,  4'd7,  8'h12, 4'h1, 1'b0, 1'b0, 1'b0);
        run_op("min/7",   8'h80,  4'd7,  8'hEE, 4'hE, 1'b0, 1'b0, 1'b0);
        run_op("7/-8",    8'd7,   4'h8,  8'h00, 4'h7, 1'b0, 1'b0, 1'b0);
        run_op("-1/-8",   8'hFF,  4'h8,  8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
        run_op("min/1",   8'h80,  4'h1,  8'h80, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("noise",   8'd20,  4'd3,  8'h06, 4'h2, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of CALC, with start asserted alongside it.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd20;
        bus.divisor  = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 4'd2;
        @(posedge clk); #1;
        chk("midrst.out", 32'({bus.busy, bus.done, bus.dbz, bus.ovf, bus.quotient, bus.remainder}), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) n++;
        end
        chk("midrst.quiet", 32'(n), 32'd0);
        run_op("post_rst", 8'd7, 4'd2, 8'h03, 4'h1, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back operations.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd7;
        bus.divisor  = 4'd2;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 40);
        chk("held.lat1", 32'(n), 32'd10);
        chk("held.q1",   32'(bus.quotient), 32'h03);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.done && n < 40);
        bus.start = 1'b0;
        chk("held.gap",  32'(n), 32'd11);
        chk("held.q2",   32'({bus.quotient, bus.remainder}), 32'h031);
        @(posedge clk); #1;
        chk("held.idle", 32'({bus.done, bus.busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: N, default 4, divisor/remainder width in bits; dividend and quotient are 2N bits.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: dividend  input  2N  signed two's-complement dividend, captured when start is accepted.
REQ-006 Port: divisor  input  N  signed two's-complement divisor, captured when start is accepted.
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 Port: done  output  1  single-cycle pulse marking valid results.
REQ-009 Port: quotient  output  2N  signed quotient.
REQ-010 Port: remainder  output  N  signed remainder.
REQ-011 Port: dbz  output  1  divide-by-zero flag, valid with done.
REQ-012 Port: ovf  output  1  overflow flag, valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after exactly 2N CALC cycles, FIX->DONE, DONE->IDLE unconditionally.
REQ-014 On accepting start, the block SHALL latch operand magnitudes |dividend| and |divisor| (2N+1 and N+1 bits internally, so -2^(2N-1) and -2^(N-1) are exact) and record both sign bits.
REQ-015 CALC SHALL run restoring unsigned division, one quotient bit per cycle, MSB first: shift partial remainder left with next dividend bit, subtract |divisor|, keep the difference and set the quotient bit when non-negative, else restore and clear the bit.
REQ-016 FIX SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative (truncation toward zero; remainder takes the dividend's sign; |remainder| < |divisor|).
REQ-017 done SHALL be high only in DONE, exactly 2N+2 cycles after the cycle in which start was sampled high in IDLE; busy SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-018 quotient, remainder, dbz, ovf SHALL update only on the edge entering DONE and SHALL hold until the next entry to DONE or reset.
REQ-019 start while not in IDLE (CALC, FIX, DONE) SHALL be ignored; operand changes after acceptance SHALL not affect the result.
REQ-020 divisor == 0: latency unchanged; dbz=1, quotient all ones, remainder=0, ovf=0.
REQ-021 dividend == -2^(2N-1) with divisor == -1: ovf=1, quotient=-2^(2N-1) (MSB only set), remainder=0, dbz=0.
REQ-022 All other operand pairs SHALL give dbz=0, ovf=0 and the exact truncated result.
REQ-023 start held high continuously SHALL produce back-to-back operations, each accepted in the IDLE cycle following DONE.

Reset
REQ-024 rst high at a rising edge SHALL force state IDLE and busy=0, done=0, quotient=0, remainder=0, dbz=0, ovf=0, from any state including mid-CALC.
REQ-025 A start sampled in the same cycle as rst SHALL be discarded.
REQ-026 After rst deasserts, the first start SHALL be accepted in the next IDLE cycle with no extra wait.

Structure
REQ-027 Shared package div_pkg SHALL hold the FSM state encoding (IDLE, CALC, FIX, DONE) and the default N.
REQ-028 One sub-module, div_step (combinational: partial remainder, divisor magnitude -> next remainder, quotient bit), SHALL implement a single restoring step; seq_divider holds FSM, iteration counter, registers and sign fix.

Verification
REQ-029 N=4, dividend=7, divisor=2, start pulse -> done 10 cycles later, quotient=8'h03, remainder=4'h1, dbz=0, ovf=0.
REQ-030 dividend=-7 (8'hF9), divisor=2 -> quotient=8'hFD (-3), remainder=4'hF (-1); dividend=100, divisor=-7 (4'h9) -> quotient=8'hF2 (-14), remainder=4'h2.
REQ-031 dividend=8'h80, divisor=4'hF -> ovf=1, quotient=8'h80, remainder=0; dividend=8'h80, divisor=4'h8 -> quotient=8'h10, remainder=0, ovf=0.
REQ-032 dividend=55, divisor=0 -> done after 10 cycles, dbz=1, quotient=8'hFF, remainder=0.
REQ-033 start accepted, rst pulsed in CALC cycle 3 -> no done, all outputs 0 next cycle; new start 7/2 -> correct result with full latency.
REQ-034 start re-asserted with new operands during CALC -> ignored, first result unchanged; start held high -> consecutive done pulses 11 cycles apart.
